instr_decode_queue: RTL and testbench
=====================================

// Module: instr_decode_queue
// PURPOSE
//  Parametrised fetch-to-decode instruction queue: buffers up to DEPTH {pc, instr} pairs from IF
//  with valid/ready handshakes on both sides, and presents the head entry already split into
//  MIPS fields (opcode/rs/rt/rd/shamt/funct/imm16/imm26) to the D stage.
//  Supports a pipeline flush that empties the queue in one cycle.
// PARAMETERS
//  DEPTH  4      number of entries; power of two, >= 2
//  PC_W   32     width of the PC carried alongside each instruction
//  NOP    32'h0  instruction word driven on out_instr/fields when the queue is empty
// PORTS
//  clk        in   1                  clock; all state updates on rising edge
//  reset      in   1                  synchronous, active-high reset
//  flush      in   1                  synchronous discard of all entries
//  in_valid   in   1                  IF offers {in_pc, in_instr}
//  in_ready   out  1                  queue accepts this cycle (= count != DEPTH)
//  in_pc      in   PC_W               PC of offered instruction
//  in_instr   in   32                 offered instruction word
//  out_valid  out  1                  head entry present (= count != 0)
//  out_ready  in   1                  D stage consumes head this cycle
//  out_pc     out  PC_W               PC of head entry; 0 when empty
//  out_instr  out  32                 head instruction; NOP when empty
//  opcode     out  6                  out_instr[31:26]
//  rs         out  5                  out_instr[25:21]
//  rt         out  5                  out_instr[20:16]
//  rd         out  5                  out_instr[15:11]
//  shamt      out  5                  out_instr[10:6]
//  funct      out  6                  out_instr[5:0]
//  imm16      out  16                 out_instr[15:0]
//  imm26      out  26                 out_instr[25:0]
//  count      out  $clog2(DEPTH+1)    current occupancy
// BEHAVIOUR
//  - Storage: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH; count register.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Both evaluated on the same edge.
//  - push only: mem[wr_ptr] <= {in_pc,in_instr}; wr_ptr+1; count+1.
//  - pop only: rd_ptr+1; count-1.
//  - push & pop together (0<count<DEPTH): both pointers advance; count unchanged.
//  - Full (count==DEPTH): in_ready=0; a pop that cycle frees a slot, but in_ready is not
//    asserted combinationally (no out_ready->in_ready path); the next push is accepted the
//    following cycle.
//  - Empty (count==0): out_valid=0; no bypass, so a push is first visible on out_valid one
//    cycle later (latency 1); out_ready is ignored while empty.
//  - Fields: purely combinational slices of out_instr; out_instr=mem[rd_ptr] when out_valid,
//    else NOP. out_pc=0 when empty.
//  - flush: on the edge, wr_ptr=rd_ptr=0 and count=0, regardless of push/pop; any push in the
//    flush cycle is dropped; out_valid=0 from the next cycle.
//  - reset: same effect as flush, with priority over flush. After reset: count=0, in_ready=1,
//    out_valid=0, out_pc=0, out_instr=NOP, fields = NOP slices.
//  - reset/flush mid-stream: discarded entries are never presented; stored memory contents
//    need not be cleared.
//  - Outputs carry no X after reset; memory contents behind an invalid head are never visible.
// TESTING
//  T1 reset: assert reset 2 cycles -> count=0, in_ready=1, out_valid=0, out_instr=32'h0.
//  T2 single push: 1 cycle in_valid, pc=0x3000, instr=0x8C080004, out_ready=0
//     -> next cycle out_valid=1, opcode=0x23, rs=0, rt=8, imm16=0x0004, count=1.
//  T3 fill: push 5 words with out_ready=0 (DEPTH=4) -> count=4 and in_ready=0 after 4th;
//     5th held until one pop; pops return words in order with matching PCs.
//  T4 simultaneous: count=2, push and pop same cycle -> count stays 2; head advances;
//     pointers wrap correctly over 3*DEPTH mixed operations against a reference model.
//  T5 flush: count=3, flush with in_valid=1 -> next cycle count=0, out_valid=0;
//     pushed word never appears on out_instr.
//  T6 R-type split: instr=0x012A4020 (add $8,$9,$10) -> opcode=0, rs=9, rt=10, rd=8,
//     shamt=0, funct=0x20.

Source files
------------

// File: rtl/instr_decode_queue_if.sv
// Fetch-to-decode queue bus: IF push side, D pop side and the decoded head fields.
// The queue takes the slave modport; the IF/D stages (or a bench) take master.
interface instr_decode_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [15:0]     imm16;
    logic [25:0]     imm26;
    logic [CW-1:0]   count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr,
        input  opcode, rs, rt, rd, shamt, funct, imm16, imm26, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr,
        output opcode, rs, rt, rd, shamt, funct, imm16, imm26, count
    );
endinterface

// File: rtl/instr_decode_queue.sv
// Circular instruction queue between IF and D; the head is presented
// pre-split into MIPS fields, with NOP/zero-PC shown whenever it is empty.
module instr_decode_queue #(
    parameter int          DEPTH = 4,
    parameter int          PC_W  = 32,
    parameter logic [31:0] NOP   = 32'h0
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  flush,
    instr_decode_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = PC_W + 32;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [EW-1:0] head;
    logic [31:0]   instr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = ~empty & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is left uninitialised; an invalid head is masked below.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush)
            mem[wr_ptr] <= {bus.in_pc, bus.in_instr};
    end

    assign head  = mem[rd_ptr];
    assign instr = empty ? NOP : head[31:0];

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out_pc    = empty ? '0 : head[EW-1:32];
    assign bus.out_instr = instr;
    assign bus.count     = count;

    assign bus.opcode = instr[31:26];
    assign bus.rs     = instr[25:21];
    assign bus.rt     = instr[20:16];
    assign bus.rd     = instr[15:11];
    assign bus.shamt  = instr[10:6];
    assign bus.funct  = instr[5:0];
    assign bus.imm16  = instr[15:0];
    assign bus.imm26  = instr[25:0];
endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: directed scenarios plus
// random traffic checked against a plain FIFO model of {pc, instr}.
module tb_instr_decode_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    bit popped = 1'b0;

    logic [63:0] exp_q[$];
    logic [63:0] h;

    instr_decode_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

    instr_decode_queue #(
        .DEPTH(DEPTH),
        .PC_W (PC_W),
        .NOP  (32'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h", n, a, e);
        end
    endtask

    // Monitor: compares the presented head/status against the model
    always @(negedge clk) begin
        popped = 1'b0;
        if (started) begin
            check("count", 64'(bus.count), 64'(exp_q.size()));
            check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() != DEPTH));
            check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                check("out_pc", 64'(bus.out_pc), 64'(h[63:32]));
                check("out_instr", 64'(bus.out_instr), 64'(h[31:0]));
                check("opcode", 64'(bus.opcode), 64'(h[31:26]));
                check("rs", 64'(bus.rs), 64'(h[25:21]));
                check("rt", 64'(bus.rt), 64'(h[20:16]));
                check("rd", 64'(bus.rd), 64'(h[15:11]));
                check("shamt", 64'(bus.shamt), 64'(h[10:6]));
                check("funct", 64'(bus.funct), 64'(h[5:0]));
                check("imm16", 64'(bus.imm16), 64'(h[15:0]));
                check("imm26", 64'(bus.imm26), 64'(h[25:0]));
                if (bus.out_ready && !reset && !flush) begin
                    void'(exp_q.pop_front());
                    popped = 1'b1;
                end
            end else begin
                check("empty_instr", 64'(bus.out_instr), 64'h0);
                check("empty_pc", 64'(bus.out_pc), 64'h0);
                check("empty_funct", 64'(bus.funct), 64'h0);
            end
        end
    end

    // Drive one cycle from posedge+1; record accepted pushes after the monitor
    task automatic step(bit v, logic [31:0] pc, logic [31:0] ins,
                        bit rdy, bit fl, bit rst);
        int occ;
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = rdy;
        flush         = fl;
        reset         = rst;
        @(negedge clk);
        #1;
        occ = exp_q.size() + (popped ? 1 : 0);
        if (rst || fl)
            exp_q.delete();
        else if (v && occ != DEPTH)
            exp_q.push_back({pc, ins});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(bit rdy);
        step(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    task automatic rnd_step(int fl_odds, int rst_odds);
        step($urandom_range(0, 1) == 1, $urandom, $urandom,
             $urandom_range(0, 2) != 0,
             $urandom_range(0, fl_odds) == 0,
             $urandom_range(0, rst_odds) == 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        reset         = 1'b1;
        @(posedge clk);
        #1;

        // T1 reset
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("t1_count", 64'(bus.count), 64'd0);
        check("t1_in_ready", 64'(bus.in_ready), 64'd1);
        check("t1_out_valid", 64'(bus.out_valid), 64'd0);
        check("t1_out_instr", 64'(bus.out_instr), 64'h0);
        check("t1_out_pc", 64'(bus.out_pc), 64'h0);
        started = 1'b1;

        // T2 single push, latency one
        step(1'b1, 32'h3000, 32'h8C080004, 1'b0, 1'b0, 1'b0);
        check("t2_out_valid", 64'(bus.out_valid), 64'd1);
        check("t2_opcode", 64'(bus.opcode), 64'h23);
        check("t2_rs", 64'(bus.rs), 64'd0);
        check("t2_rt", 64'(bus.rt), 64'd8);
        check("t2_imm16", 64'(bus.imm16), 64'h4);
        check("t2_count", 64'(bus.count), 64'd1);
        check("t2_out_pc", 64'(bus.out_pc), 64'h3000);
        idle(1'b1);
        check("t2_drained", 64'(bus.count), 64'd0);

        // T3 fill past full; the stalled push lands only after a pop
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i),
                 1'b0, 1'b0, 1'b0);
        check("t3_full_count", 64'(bus.count), 64'd4);
        check("t3_full_ready", 64'(bus.in_ready), 64'd0);
        step(1'b1, 32'h110, 32'hA000_0004, 1'b0, 1'b0, 1'b0);
        check("t3_held", 64'(bus.count), 64'd4);
        step(1'b1, 32'h110, 32'hA000_0004, 1'b1, 1'b0, 1'b0);
        check("t3_pop_full", 64'(bus.count), 64'd3);
        check("t3_ready_back", 64'(bus.in_ready), 64'd1);
        step(1'b1, 32'h110, 32'hA000_0004, 1'b0, 1'b0, 1'b0);
        check("t3_refill", 64'(bus.count), 64'd4);
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("t3_empty", 64'(bus.count), 64'd0);

        // T4 simultaneous push and pop, then mixed traffic
        step(1'b1, 32'h200, 32'h1111_0001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h204, 32'h1111_0002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h208, 32'h1111_0003, 1'b1, 1'b0, 1'b0);
        check("t4_count", 64'(bus.count), 64'd2);
        check("t4_head_pc", 64'(bus.out_pc), 64'h204);
        for (int i = 0; i < 3 * DEPTH; i++) rnd_step(1000, 1000);

        // T5 flush drops the queue and the same-cycle push
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h400 + 32'(4 * i), 32'h2222_0000 + 32'(i),
                 1'b0, 1'b0, 1'b0);
        check("t5_pre_count", 64'(bus.count), 64'd3);
        step(1'b1, 32'h5000, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        check("t5_count", 64'(bus.count), 64'd0);
        check("t5_out_valid", 64'(bus.out_valid), 64'd0);
        check("t5_out_instr", 64'(bus.out_instr), 64'h0);
        idle(1'b1);
        check("t5_still_empty", 64'(bus.out_instr), 64'h0);

        // T6 R-type split
        step(1'b1, 32'h600, 32'h012A4020, 1'b0, 1'b0, 1'b0);
        check("t6_opcode", 64'(bus.opcode), 64'h0);
        check("t6_rs", 64'(bus.rs), 64'd9);
        check("t6_rt", 64'(bus.rt), 64'd10);
        check("t6_rd", 64'(bus.rd), 64'd8);
        check("t6_shamt", 64'(bus.shamt), 64'd0);
        check("t6_funct", 64'(bus.funct), 64'h20);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) rnd_step(30, 60);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
        check("final_empty", 64'(bus.count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
